// File: rtl/booth_iter_core.sv
// ----------------------------------------------------------------------------
// booth_iter_core
//
// Radix-2 Booth iterative signed multiplier core. It sits in front of the final
// product register. On an accepted start it latches two signed WIDTH-bit
// operands. It then runs WIDTH add/subtract plus arithmetic-shift iterations,
// one per clock. When the iterations are finished it pulses o_ld for one cycle.
// The downstream product register then captures o_pp_out[PP_WIDTH-1:1], which
// is the signed 2*WIDTH-bit product.
//
// Ports
//   clk             in   1         rising-edge clock
//   reset           in   1         synchronous, active-high, overrides all inputs
//   i_start         in   1         operation request, accepted only when idle
//   i_multiplicand  in   WIDTH     signed multiplicand M, sampled on accept
//   i_multiplier    in   WIDTH     signed multiplier Q, sampled on accept
//   o_busy          out  1         high while calculating and in the done cycle
//   o_ld            out  1         one-cycle load strobe for the product register
//   o_pp_out        out  PP_WIDTH  packed partial product {A[WIDTH-1:0], Q, Q_1}
// ----------------------------------------------------------------------------
module booth_iter_core #(
  parameter int WIDTH    = 16,
  parameter int PP_WIDTH = 2*WIDTH+1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic [WIDTH-1:0]    i_multiplicand,
  input  logic [WIDTH-1:0]    i_multiplier,
  output logic                o_busy,
  output logic                o_ld,
  output logic [PP_WIDTH-1:0] o_pp_out
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  // A carries one guard bit above the exported width. This lets A - M with
  // M = -2^(WIDTH-1) stay representable.
  logic [WIDTH:0]  r_a;
  logic [WIDTH-1:0] r_q;
  logic            r_q1;
  logic [WIDTH-1:0] r_m;
  logic [CW-1:0]   r_count;

  logic            w_accept;
  logic [WIDTH:0]  w_m_ext;
  logic [WIDTH:0]  w_sum;

  assign w_accept = (r_state == IDLE) && i_start;
  assign w_m_ext  = {r_m[WIDTH-1], r_m};

  // Booth recoding of the current multiplier bit pair.
  always_comb begin
    w_sum = r_a;
    case ({r_q[0], r_q1})
      2'b01:   w_sum = r_a + w_m_ext;
      2'b10:   w_sum = r_a - w_m_ext;
      default: w_sum = r_a;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and status outputs. The last iteration is the one that
  // sees count == WIDTH-1.
  always_comb begin
    w_next_state = r_state;
    o_busy       = 1'b0;
    o_ld         = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next_state = CALC;
        end
      end
      CALC: begin
        o_busy = 1'b1;
        if (r_count == LAST) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        o_busy       = 1'b1;
        o_ld         = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Datapath. An accept loads the operands and clears the accumulator.
  // Each CALC cycle does an add/sub followed by an arithmetic right shift
  // of {A,Q,Q_1}. The registers hold their values outside CALC, so the
  // final product stays visible until the next accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_m     <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_a     <= '0;
      r_q     <= i_multiplier;
      r_q1    <= 1'b0;
      r_m     <= i_multiplicand;
      r_count <= '0;
    end else if (r_state == CALC) begin
      r_a     <= {w_sum[WIDTH], w_sum[WIDTH:1]};
      r_q     <= {w_sum[0], r_q[WIDTH-1:1]};
      r_q1    <= r_q[0];
      r_count <= r_count + CW'(1);
    end
  end

  assign o_pp_out = {r_a[WIDTH-1:0], r_q, r_q1};

endmodule

// File: tb/tb_booth_iter_core.sv
// ----------------------------------------------------------------------------
// tb_booth_iter_core
//
// Self-checking bench for booth_iter_core at WIDTH=16. It applies a table of
// known products and hand-written multi-cycle sequences: start ignored while
// busy, start held high, and reset in the middle of an operation. It then
// applies randomized operands and checks each result against plain signed
// multiplication.
// ----------------------------------------------------------------------------
module tb_booth_iter_core;

  localparam int W  = 16;
  localparam int PW = 2*W+1;

  logic          clk;
  logic          reset;
  logic          i_start;
  logic [W-1:0]  i_multiplicand;
  logic [W-1:0]  i_multiplier;
  logic          o_busy;
  logic          o_ld;
  logic [PW-1:0] o_pp_out;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[10];
  int   ldQ[$];

  booth_iter_core #(.WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_start        (i_start),
    .i_multiplicand (i_multiplicand),
    .i_multiplier   (i_multiplier),
    .o_busy         (o_busy),
    .o_ld           (o_ld),
    .o_pp_out       (o_pp_out)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value with the value the bench requires.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: the product of two signed operands.
  function automatic logic [2*W-1:0] refProduct(input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
    longint pa;
    pa = longint'($signed(a)) * longint'($signed(b));
    return pa[2*W-1:0];
  endfunction

  // Runs one full operation from an idle core. It checks the ld timing,
  // the busy level, the product, and the idle state afterwards.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2*W-1:0] expP, input string tag);
    int             ldAt;
    int             ldCnt;
    bit             busyOk;
    logic [2*W-1:0] p;
    ldAt   = -1;
    ldCnt  = 0;
    busyOk = 1'b1;
    p      = '0;
    @(negedge clk);
    i_start        = 1'b1;
    i_multiplicand = a;
    i_multiplier   = b;
    for (int k = 1; k <= W+1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        i_start        = 1'b0;
        i_multiplicand = W'($urandom);
        i_multiplier   = W'($urandom);
      end
      if (o_ld) begin
        ldCnt++;
        ldAt = k;
        p    = o_pp_out[PW-1:1];
      end
      if (!o_busy) busyOk = 1'b0;
    end
    checkOutput({tag, " ld cycle"}, 64'(ldAt), 64'(W+1));
    checkOutput({tag, " ld count"}, 64'(ldCnt), 64'd1);
    checkOutput({tag, " busy during op"}, 64'(busyOk), 64'd1);
    checkOutput({tag, " product"}, 64'(p), 64'(expP));
    @(negedge clk);
    checkOutput({tag, " busy after"}, 64'(o_busy), 64'd0);
    checkOutput({tag, " ld after"}, 64'(o_ld), 64'd0);
    checkOutput({tag, " product held"}, 64'(o_pp_out[PW-1:1]), 64'(expP));
  endtask

  // Waits, with a cycle bound, for the core to return to idle.
  task automatic waitIdle(input string tag);
    for (int k = 0; k < 40; k++) begin
      if (!o_busy) break;
      @(negedge clk);
    end
    checkOutput({tag, " drained to idle"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    int             ldCnt;
    int             ldAt;
    bit             idleOk;
    logic [2*W-1:0] p;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
    vecs[1] = '{16'hFFF9, 16'h0003, 32'hFFFFFFEB};
    vecs[2] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    vecs[3] = '{16'h8000, 16'h8000, 32'h40000000};
    vecs[4] = '{16'h7FFF, 16'h8000, 32'hC0008000};
    vecs[5] = '{16'h8000, 16'h7FFF, 32'hC0008000};
    vecs[6] = '{16'h0000, 16'h1234, 32'h00000000};
    vecs[7] = '{16'h1234, 16'hFFFF, 32'hFFFFEDCC};
    vecs[8] = '{16'hFFFF, 16'hFFFF, 32'h00000001};
    vecs[9] = '{16'h8000, 16'h0001, 32'hFFFF8000};

    reset          = 1'b1;
    i_start        = 1'b1;
    i_multiplicand = 16'h1111;
    i_multiplier   = 16'h2222;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 64'(o_busy), 64'd0);
    checkOutput("reset ld", 64'(o_ld), 64'd0);
    checkOutput("reset pp_out", 64'(o_pp_out), 64'd0);
    reset   = 1'b0;
    i_start = 1'b0;

    $display("[TB] table vectors");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
    end

    // Start pulses while busy (CALC and DONE) must be ignored.
    $display("[TB] start ignored while busy");
    ldCnt  = 0;
    ldAt   = -1;
    idleOk = 1'b1;
    p      = '0;
    @(negedge clk);
    i_start        = 1'b1;
    i_multiplicand = 16'h0003;
    i_multiplier   = 16'h0005;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (o_ld) begin
        ldCnt++;
        ldAt = k;
        p    = o_pp_out[PW-1:1];
      end
      if (k >= 18 && (o_busy || o_ld)) idleOk = 1'b0;
      if (k == 5 || k == 17) begin
        i_start        = 1'b1;
        i_multiplicand = 16'h7777;
        i_multiplier   = 16'h1111;
      end else begin
        i_start = 1'b0;
      end
    end
    checkOutput("ignore ld count", 64'(ldCnt), 64'd1);
    checkOutput("ignore ld cycle", 64'(ldAt), 64'd17);
    checkOutput("ignore product", 64'(p), 64'h0000000F);
    checkOutput("ignore stays idle", 64'(idleOk), 64'd1);
    checkOutput("ignore product held", 64'(o_pp_out[PW-1:1]), 64'h0000000F);

    // A held start re-accepts in every first idle cycle, so the period is W+2.
    $display("[TB] start held high");
    ldQ.delete();
    @(negedge clk);
    i_start        = 1'b1;
    i_multiplicand = 16'h0003;
    i_multiplier   = 16'h0005;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (o_ld) begin
        ldQ.push_back(k);
        checkOutput($sformatf("held product at %0d", k),
                    64'(o_pp_out[PW-1:1]), 64'h0000000F);
      end
    end
    i_start = 1'b0;
    checkOutput("held ld count", 64'(ldQ.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("held ld %0d cycle", i),
                  64'((ldQ.size() > i) ? ldQ[i] : -1), 64'(17 + 18*i));
    end
    waitIdle("held");

    // A reset in the middle of an operation aborts it without any ld pulse.
    $display("[TB] reset mid-operation");
    ldCnt = 0;
    @(negedge clk);
    i_start        = 1'b1;
    i_multiplicand = 16'h0003;
    i_multiplier   = 16'h0005;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_ld) ldCnt++;
    end
    checkOutput("abort busy before reset", 64'(o_busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort busy", 64'(o_busy), 64'd0);
    checkOutput("abort ld", 64'(o_ld), 64'd0);
    checkOutput("abort pp_out", 64'(o_pp_out), 64'd0);
    reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (o_ld) ldCnt++;
    end
    checkOutput("abort no ld", 64'(ldCnt), 64'd0);

    $display("[TB] random operands");
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: rb = '1;
        2: ra = 16'h8000;
        default: ;
      endcase
      applyStimulus(ra, rb, refProduct(ra, rb), $sformatf("rand%0d", n));
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
